digit_serial_adder: RTL

//  Parametrised multi-cycle add/subtract unit; successor to the 4-bit single-cycle adder.

---
 rtl/digit_serial_adder.sv | 104 ++++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/subtract, DIGIT bits per clock LSB first, carry held between digits
module digit_serial_adder #(
    parameter int WIDTH = 4,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    if (DIGIT < 1 || WIDTH < 1 || WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d, ps_next;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, last;
    logic [DIGIT:0]   dig;
    always_comb begin
        dig     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
        ps_next = WIDTH'({dig[DIGIT-1:0], ps_q} >> DIGIT);
        last    = cnt_q == CW'(N - 1);
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        ps_d    = ps_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == S_IDLE && start) begin
            state_d = S_RUN;
            a_d     = a;
            b_d     = sub ? ~b : b;
            c_d     = sub ? ~cin : cin;
            cnt_d   = '0;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b_d[WIDTH-1];
        end else if (state_q == S_RUN) begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            c_d   = dig[DIGIT];
            cnt_d = cnt_q + CW'(1);
            ps_d  = ps_next;
            if (last) begin
                state_d = S_DONE;
                sum_d   = ps_next;
                cout_d  = dig[DIGIT];
                ovf_d   = (a_msb_q == b_msb_q) && (ps_next[WIDTH-1] != a_msb_q);
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            ps_q    <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
    assign busy = state_q != S_IDLE;
    assign done = state_q == S_DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule
